xhost_seq: RTL and testbench

- Host-side master for the picoVersat native register-file interface (par_addr/par_we/par_in/par_out).
- Accepts a valid/ready command stream (WRITE, READ, POLL) and converts each command into cycles on the native interface.
- Returns one response per command on a valid/ready response channel.
- Sits between a testbench or host bus bridge and the controller top, so software can load parameters, start the controller and wait for completion flags.

---
 rtl/xhost_seq_pkg.sv | 26 ++
 rtl/xhost_seq.sv | 162 ++++++++++++++++
 tb/tb_xhost_seq.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/xhost_seq_pkg.sv
// Shared opcodes, FSM states and counter sizing for the picoVersat host sequencer.
package xhost_seq_pkg;

  typedef enum logic [1:0] {
    XHOST_OP_WRITE = 2'd0,
    XHOST_OP_READ  = 2'd1,
    XHOST_OP_POLL  = 2'd2,
    XHOST_OP_RSVD  = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR      = 3'd1,
    S_RD_WAIT = 3'd2,
    S_CMP     = 3'd3,
    S_RESP    = 3'd4
  } state_e;

  localparam int WCNT_W = 2;  // holds READ_LAT-1 for READ_LAT in 1..4

  // Poll counter width; at least one bit even for POLL_MAX=1.
  function automatic int pcnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/xhost_seq.sv
// Host command sequencer driving the picoVersat native register-file port.
// Optional XHOST_TRAP_ABORT_EN adds a trap input that aborts an in-flight POLL.
module xhost_seq
  import xhost_seq_pkg::*;
#(
  parameter int REGF_ADDR_W = 4,
  parameter int DATA_W      = 32,
  parameter int READ_LAT    = 1,
  parameter int POLL_MAX    = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [1:0]             cmd_op,
  input  logic [REGF_ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0]      cmd_data,
  input  logic [DATA_W-1:0]      cmd_mask,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [DATA_W-1:0]      rsp_data,
  output logic                   rsp_err,
  output logic [REGF_ADDR_W-1:0] par_addr,
  output logic                   par_we,
  output logic [DATA_W-1:0]      par_in,
  input  logic [DATA_W-1:0]      par_out
`ifdef XHOST_TRAP_ABORT_EN
  ,
  input  logic                   trap
`endif
);

  localparam int PCW = pcnt_w(POLL_MAX);

  state_e                 state_q, state_d;
  op_e                    op_q, op_d;
  logic                   rdy_q;
  logic [DATA_W-1:0]      data_q, data_d, mask_q, mask_d;
  logic [DATA_W-1:0]      par_in_q, par_in_d, rsp_data_q, rsp_data_d;
  logic                   rsp_err_q, rsp_err_d;
  logic [REGF_ADDR_W-1:0] par_addr_q, par_addr_d;
  logic [WCNT_W-1:0]      wcnt_q, wcnt_d;
  logic [PCW-1:0]         pcnt_q, pcnt_d;
  logic                   trap_abort;

`ifdef XHOST_TRAP_ABORT_EN
  assign trap_abort = trap && (op_q == XHOST_OP_POLL);
`else
  assign trap_abort = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    data_d     = data_q;
    mask_d     = mask_q;
    par_in_d   = par_in_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    par_addr_d = par_addr_q;
    wcnt_d     = wcnt_q;
    pcnt_d     = pcnt_q;
    case (state_q)
      S_IDLE: if (cmd_valid && rdy_q) begin
        op_d       = op_e'(cmd_op);
        data_d     = cmd_data;
        mask_d     = cmd_mask;
        par_addr_d = cmd_addr;
        case (op_e'(cmd_op))
          XHOST_OP_WRITE: begin
            par_in_d = cmd_data;
            state_d  = S_WR;
          end
          XHOST_OP_READ, XHOST_OP_POLL: begin
            wcnt_d  = WCNT_W'(READ_LAT - 1);
            pcnt_d  = '0;
            state_d = S_RD_WAIT;
          end
          default: begin
            rsp_data_d = '0;
            rsp_err_d  = 1'b1;
            state_d    = S_RESP;
          end
        endcase
      end
      S_WR: begin
        rsp_data_d = data_q;
        rsp_err_d  = 1'b0;
        state_d    = S_RESP;
      end
      S_RD_WAIT: begin
        if (trap_abort) begin
          rsp_data_d = '1;
          rsp_err_d  = 1'b1;
          state_d    = S_RESP;
        end else if (wcnt_q == '0) begin
          rsp_data_d = par_out;
          rsp_err_d  = 1'b0;
          state_d    = (op_q == XHOST_OP_READ) ? S_RESP : S_CMP;
        end else begin
          wcnt_d = wcnt_q - WCNT_W'(1);
        end
      end
      S_CMP: begin
        if (trap_abort) begin
          rsp_data_d = '1;
          rsp_err_d  = 1'b1;
          state_d    = S_RESP;
        end else if ((rsp_data_q & mask_q) == (data_q & mask_q)) begin
          rsp_err_d = 1'b0;
          state_d   = S_RESP;
        end else if (pcnt_q == PCW'(POLL_MAX - 1)) begin
          rsp_err_d = 1'b1;  // timeout keeps the last polled value
          state_d   = S_RESP;
        end else begin
          pcnt_d  = pcnt_q + PCW'(1);
          wcnt_d  = WCNT_W'(READ_LAT - 1);
          state_d = S_RD_WAIT;
        end
      end
      S_RESP: if (rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      op_q       <= XHOST_OP_WRITE;
      rdy_q      <= 1'b0;
      data_q     <= '0;
      mask_q     <= '0;
      par_in_q   <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      par_addr_q <= '0;
      wcnt_q     <= '0;
      pcnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      rdy_q      <= 1'b1;  // keeps cmd_ready low for the reset cycle itself
      data_q     <= data_d;
      mask_q     <= mask_d;
      par_in_q   <= par_in_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
      par_addr_q <= par_addr_d;
      wcnt_q     <= wcnt_d;
      pcnt_q     <= pcnt_d;
    end
  end

  assign cmd_ready = rdy_q && (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign par_addr  = par_addr_q;
  assign par_we    = (state_q == S_WR);
  assign par_in    = par_in_q;

endmodule

// File: tb/tb_xhost_seq.sv
// Directed bench for xhost_seq: two instances (READ_LAT=1/POLL_MAX=1024, READ_LAT=2/POLL_MAX=8) with register-file models.
module tb_xhost_seq;

  typedef struct {
    logic [31:0] d;
    logic        e;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid [2];
  logic        cmd_ready [2];
  logic [1:0]  cmd_op    [2];
  logic [3:0]  cmd_addr  [2];
  logic [31:0] cmd_data  [2];
  logic [31:0] cmd_mask  [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_data  [2];
  logic        rsp_err   [2];
  logic [3:0]  par_addr  [2];
  logic        par_we    [2];
  logic [31:0] par_in    [2];
  logic [31:0] par_out0, par_out1;
`ifdef XHOST_TRAP_ABORT_EN
  logic        trap = 1'b0;
`endif

  logic [31:0] regs0 [16] = '{default: '0};
  logic [31:0] regs1 [16] = '{default: '0};
  int          we_cnt [2] = '{0, 0};
  logic [3:0]  last_addr [2];
  logic [31:0] last_data [2];
  int          cyc = 0;
  int          set_at = -1;

  exp_t        sb [$];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  xhost_seq #(.REGF_ADDR_W(4), .DATA_W(32), .READ_LAT(1), .POLL_MAX(1024)) u0 (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]), .cmd_op(cmd_op[0]),
    .cmd_addr(cmd_addr[0]), .cmd_data(cmd_data[0]), .cmd_mask(cmd_mask[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_data(rsp_data[0]),
    .rsp_err(rsp_err[0]), .par_addr(par_addr[0]), .par_we(par_we[0]),
    .par_in(par_in[0]), .par_out(par_out0)
`ifdef XHOST_TRAP_ABORT_EN
    , .trap(trap)
`endif
  );

  xhost_seq #(.REGF_ADDR_W(4), .DATA_W(32), .READ_LAT(2), .POLL_MAX(8)) u1 (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]), .cmd_op(cmd_op[1]),
    .cmd_addr(cmd_addr[1]), .cmd_data(cmd_data[1]), .cmd_mask(cmd_mask[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_data(rsp_data[1]),
    .rsp_err(rsp_err[1]), .par_addr(par_addr[1]), .par_we(par_we[1]),
    .par_in(par_in[1]), .par_out(par_out1)
`ifdef XHOST_TRAP_ABORT_EN
    , .trap(1'b0)
`endif
  );

  // Register-file models: combinational read for u0, one-register read for u1.
  assign par_out0 = regs0[par_addr[0]];
  always @(posedge clk) par_out1 <= regs1[par_addr[1]];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (cyc == set_at) regs0[0] <= regs0[0] | 32'h1;
    if (par_we[0]) begin
      regs0[par_addr[0]] <= par_in[0];
      we_cnt[0]    <= we_cnt[0] + 1;
      last_addr[0] <= par_addr[0];
      last_data[0] <= par_in[0];
    end
    if (par_we[1]) begin
      regs1[par_addr[1]] <= par_in[1];
      we_cnt[1]    <= we_cnt[1] + 1;
      last_addr[1] <= par_addr[1];
      last_data[1] <= par_in[1];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One command on instance k; lat>0 checks negedges from accept to rsp_valid, hold>0 applies backpressure.
  task automatic run(input int k, input logic [1:0] op, input logic [3:0] a,
                     input logic [31:0] d, input logic [31:0] m,
                     input logic [31:0] ed, input logic ee, input int lat, input int hold);
    exp_t e;
    int   n;
    int   wc;
    e.d = ed;
    e.e = ee;
    @(negedge clk);
    rsp_ready[k] = (hold == 0);
    cmd_valid[k] = 1'b1;
    cmd_op[k]    = op;
    cmd_addr[k]  = a;
    cmd_data[k]  = d;
    cmd_mask[k]  = m;
    n = 0;
    while (!cmd_ready[k] && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("cmd_ready_idle", {31'd0, cmd_ready[k]}, 32'd1);
    @(posedge clk);
    sb.push_back(e);
    #1;
    cmd_valid[k] = 1'b0;
    cmd_op[k]    = 2'($urandom);
    cmd_addr[k]  = 4'($urandom);
    cmd_data[k]  = $urandom;
    cmd_mask[k]  = $urandom;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rsp_valid[k] && n < 500);
    check("rsp_arrives", {31'd0, rsp_valid[k]}, 32'd1);
    if (rsp_valid[k] && sb.size() > 0) begin
      e = sb.pop_front();
      check("rsp_data", rsp_data[k], e.d);
      check("rsp_err", {31'd0, rsp_err[k]}, {31'd0, e.e});
      if (lat > 0) check("rsp_latency", n, lat);
    end
    if (hold > 0) begin
      wc = we_cnt[k];
      repeat (hold) begin
        @(negedge clk);
        check("bp_valid", {31'd0, rsp_valid[k]}, 32'd1);
        check("bp_data", rsp_data[k], e.d);
        check("bp_ready", {31'd0, cmd_ready[k]}, 32'd0);
        check("bp_we", we_cnt[k], wc);
        check("bp_addr", {28'd0, par_addr[k]}, {28'd0, a});
      end
      rsp_ready[k] = 1'b1;
    end
    @(posedge clk);
    #1;
    check("rsp_released", {31'd0, rsp_valid[k]}, 32'd0);
    check("ready_after_rsp", {31'd0, cmd_ready[k]}, 32'd1);
  endtask

  initial begin
    int   w;
    int   n;
    logic seen;
    exp_t e;
    for (int k = 0; k < 2; k++) begin
      cmd_valid[k] = 1'b0;
      cmd_op[k]    = '0;
      cmd_addr[k]  = '0;
      cmd_data[k]  = '0;
      cmd_mask[k]  = '0;
      rsp_ready[k] = 1'b1;
    end

    // Reset state
    #12;
    for (int k = 0; k < 2; k++) begin
      check("rst_cmd_ready", {31'd0, cmd_ready[k]}, 32'd0);
      check("rst_rsp_valid", {31'd0, rsp_valid[k]}, 32'd0);
      check("rst_rsp_data", rsp_data[k], 32'd0);
      check("rst_par_we", {31'd0, par_we[k]}, 32'd0);
      check("rst_par_addr", {28'd0, par_addr[k]}, 32'd0);
      check("rst_par_in", par_in[k], 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("ready_after_rst", {31'd0, cmd_ready[0]}, 32'd1);

    // WRITE then READ, READ_LAT=1
    w = we_cnt[0];
    run(0, 2'd0, 4'd3, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 1'b0, 2, 0);
    check("wr_pulses", we_cnt[0], w + 1);
    check("wr_addr", {28'd0, last_addr[0]}, 32'd3);
    check("wr_data", last_data[0], 32'hDEADBEEF);
    run(0, 2'd1, 4'd3, 32'h0, 32'h0, 32'hDEADBEEF, 1'b0, 2, 0);

    // WRITE then READ, READ_LAT=2
    w = we_cnt[1];
    run(1, 2'd0, 4'd3, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 1'b0, 2, 0);
    check("wr1_pulses", we_cnt[1], w + 1);
    run(1, 2'd1, 4'd3, 32'h0, 32'h0, 32'hDEADBEEF, 1'b0, 3, 0);

    // POLL bit0 of reg0, set 50 cycles after issue
    w = we_cnt[0];
    set_at = cyc + 50;
    run(0, 2'd2, 4'd0, 32'h1, 32'h1, 32'h1, 1'b0, 0, 0);
    check("poll_no_we", we_cnt[0], w);

    // POLL timeout after 8 reads of 3 cycles each
    run(1, 2'd2, 4'd0, 32'h1, 32'h1, 32'h0, 1'b1, 25, 0);

    // Zero mask matches on the first read; partial mask match
    run(0, 2'd0, 4'd7, 32'h00001234, 32'h0, 32'h00001234, 1'b0, 2, 0);
    run(0, 2'd2, 4'd7, 32'h5, 32'h0, 32'h00001234, 1'b0, 3, 0);
    run(1, 2'd0, 4'd9, 32'h0000003A, 32'h0, 32'h0000003A, 1'b0, 2, 0);
    run(1, 2'd2, 4'd9, 32'h00000030, 32'h000000F0, 32'h0000003A, 1'b0, 4, 0);

    // Backpressure on a READ
    run(0, 2'd1, 4'd3, 32'h0, 32'h0, 32'hDEADBEEF, 1'b0, 2, 10);

    // Reserved opcode
    w = we_cnt[0];
    run(0, 2'd3, 4'd6, 32'hCAFEF00D, 32'h0, 32'h0, 1'b1, 1, 0);
    check("rsvd_no_we", we_cnt[0], w);

    // Write so par_in is non-zero, then reset in the middle of a POLL
    run(0, 2'd0, 4'd4, 32'hA5A5A5A5, 32'h0, 32'hA5A5A5A5, 1'b0, 2, 0);
    @(negedge clk);
    cmd_valid[0] = 1'b1;
    cmd_op[0]    = 2'd2;
    cmd_addr[0]  = 4'd5;
    cmd_data[0]  = 32'h1;
    cmd_mask[0]  = 32'h1;
    @(posedge clk);
    e.d = 32'h0;
    e.e = 1'b0;
    sb.push_back(e);
    #1;
    cmd_valid[0] = 1'b0;
    w = we_cnt[0];
    repeat (3) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_cmd_ready", {31'd0, cmd_ready[0]}, 32'd0);
    check("mid_rst_rsp_valid", {31'd0, rsp_valid[0]}, 32'd0);
    check("mid_rst_rsp_data", rsp_data[0], 32'd0);
    check("mid_rst_rsp_err", {31'd0, rsp_err[0]}, 32'd0);
    check("mid_rst_par_addr", {28'd0, par_addr[0]}, 32'd0);
    check("mid_rst_par_we", {31'd0, par_we[0]}, 32'd0);
    check("mid_rst_par_in", par_in[0], 32'd0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("mid_rst_ready", {31'd0, cmd_ready[0]}, 32'd1);
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      seen = seen | rsp_valid[0];
    end
    check("mid_rst_no_rsp", {31'd0, seen}, 32'd0);
    check("mid_rst_no_we", we_cnt[0], w);

    // Commands still work after the abort
    run(0, 2'd1, 4'd4, 32'h0, 32'h0, 32'hA5A5A5A5, 1'b0, 2, 0);

`ifdef XHOST_TRAP_ABORT_EN
    // Trap during a never-matching POLL
    @(negedge clk);
    cmd_valid[0] = 1'b1;
    cmd_op[0]    = 2'd2;
    cmd_addr[0]  = 4'd5;
    cmd_data[0]  = 32'h1;
    cmd_mask[0]  = 32'h1;
    @(posedge clk);
    e.d = 32'hFFFFFFFF;
    e.e = 1'b1;
    sb.push_back(e);
    #1;
    cmd_valid[0] = 1'b0;
    repeat (4) @(negedge clk);
    check("trap_pre_valid", {31'd0, rsp_valid[0]}, 32'd0);
    trap = 1'b1;
    @(negedge clk);
    trap = 1'b0;
    check("trap_valid", {31'd0, rsp_valid[0]}, 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("trap_data", rsp_data[0], e.d);
      check("trap_err", {31'd0, rsp_err[0]}, {31'd0, e.e});
    end
    @(posedge clk);
    #1;
    check("trap_released", {31'd0, rsp_valid[0]}, 32'd0);
    // READ is unaffected by trap
    n = 0;
    fork
      begin
        @(negedge clk);
        trap = 1'b1;
        repeat (6) @(negedge clk);
        trap = 1'b0;
      end
      run(0, 2'd1, 4'd4, 32'h0, 32'h0, 32'hA5A5A5A5, 1'b0, 2, 0);
    join
`endif

    check("sb_empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
